// File: rtl/cordic_seq.sv
// cordic_seq: iterative rotation-mode CORDIC, one shift-add stage reused ITERS times to produce cos/sin of one angle.
// Latency: ITERS cycles from the accept edge to out_valid (fewer with CORDIC_SEQ_EARLY_EN when z hits exactly 0).
// Backpressure: one operation in flight; in_ready low in RUN/DONE, result held in DONE until out_ready.
//
// Ports:
//   clk, rst              sole clock, synchronous active-high reset
//   in_valid/in_ready     angle handshake; in_angle is signed Q(1.FRAC_BITS) radians, |angle| <= pi/2
//   out_valid/out_ready   result handshake; cos_out/sin_out signed Q(1.FRAC_BITS)
//   busy                  high while iterating
// Optional feature: define CORDIC_SEQ_EARLY_EN to leave RUN as soon as an iteration drives z to exactly 0.

module cordic_seq #(
    parameter int FRAC_BITS = 20,
    parameter int ITERS     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [FRAC_BITS+1:0] in_angle,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [FRAC_BITS+1:0] cos_out,
    output logic signed [FRAC_BITS+1:0] sin_out,
    output logic                        busy
);

    localparam int W  = FRAC_BITS + 2;
    localparam int IW = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [IW-1:0] LAST_I = IW'(ITERS - 1);

    // Constants below are tabulated at 20 fraction bits and rescaled to FRAC_BITS.
    function automatic logic [W-1:0] scale20(input logic [63:0] v20);
        logic [63:0] v;
        int          sh;
        sh = FRAC_BITS - 20;
        if (sh >= 0) v = v20 << sh;
        else         v = v20 >> (-sh);
        return v[W-1:0];
    endfunction

    // atan(2^-idx) truncated; for idx >= 20 atan(x) ~= x to well below one LSB.
    function automatic logic [W-1:0] atan_rom(input logic [IW-1:0] idx_in);
        logic [63:0] v;
        int          idx;
        idx = int'(idx_in);
        case (idx)
            0:       v = 64'd823549;
            1:       v = 64'd486169;
            2:       v = 64'd256878;
            3:       v = 64'd130395;
            4:       v = 64'd65450;
            5:       v = 64'd32757;
            6:       v = 64'd16382;
            7:       v = 64'd8191;
            8:       v = 64'd4095;
            9:       v = 64'd2047;
            10:      v = 64'd1023;
            11:      v = 64'd511;
            12:      v = 64'd255;
            13:      v = 64'd127;
            14:      v = 64'd63;
            15:      v = 64'd31;
            16:      v = 64'd15;
            17:      v = 64'd7;
            18:      v = 64'd3;
            19:      v = 64'd1;
            default: v = 64'd0;
        endcase
        if (idx < 20) begin
            return scale20(v);
        end else if (idx <= FRAC_BITS) begin
            v = 64'd1 << (FRAC_BITS - idx);
            return v[W-1:0];
        end else begin
            return '0;
        end
    endfunction

    // CORDIC gain compensation 0.607253, pre-loaded into x so no final multiply is needed.
    localparam logic [W-1:0] K_INIT = scale20(64'h9B74F);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic signed [W-1:0] x, y, z;
    logic        [IW-1:0] i;

    logic signed [W-1:0] x_sh, y_sh, a;
    logic signed [W-1:0] x_upd, y_upd, z_upd;
    logic                z_pos;
    logic                run_exit;

    // ---------------- shift-add rotation stage ----------------
    always_comb begin
        x_sh  = x >>> i;
        y_sh  = y >>> i;
        a     = atan_rom(i);
        z_pos = !z[W-1] && (z != '0);
        if (z_pos) begin
            x_upd = x + y_sh;
            y_upd = y - x_sh;
            z_upd = z - a;
        end else begin
            x_upd = x - y_sh;
            y_upd = y + x_sh;
            z_upd = z + a;
        end
`ifdef CORDIC_SEQ_EARLY_EN
        run_exit = (i == LAST_I) || (z_upd == '0);
`else
        run_exit = (i == LAST_I);
`endif
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid) state_nxt = S_RUN;
            S_RUN:   if (run_exit) state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs (pure state decode) ----------------
    always_comb begin
        in_ready  = (state == S_IDLE);
        busy      = (state == S_RUN);
        out_valid = (state == S_DONE);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            x       <= '0;
            y       <= '0;
            z       <= '0;
            i       <= '0;
            cos_out <= '0;
            sin_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x <= K_INIT;
                        y <= '0;
                        z <= in_angle;
                        i <= '0;
                    end
                end
                S_RUN: begin
                    x <= x_upd;
                    y <= y_upd;
                    z <= z_upd;
                    i <= i + IW'(1);
                    // The rotation leaves y = -sin, hence the negation.
                    if (run_exit) begin
                        cos_out <= x_upd;
                        sin_out <= -y_upd;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_seq.sv
// Directed self-checking bench for cordic_seq: reset, three angles, backpressure, reset mid-run,
// and (when built with CORDIC_SEQ_EARLY_EN) the early-exit case.
// Outputs are sampled 1 time unit after the rising edge; inputs change at that same point.

module tb_cordic_seq;

    localparam int FB  = 20;
    localparam int W   = FB + 2;
    localparam int TOL = 48;

    localparam int ANG_PI6    = 549033;
    localparam int ANG_NPI2   = -1647099;
    localparam int COS_PI6    = 908093;
    localparam int SIN_PI6    = 524288;
    localparam int ONE        = 1048576;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_angle;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] cos_out;
    logic signed [W-1:0] sin_out;
    logic                busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cordic_seq #(.FRAC_BITS(FB), .ITERS(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_angle  (in_angle),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cos_out   (cos_out),
        .sin_out   (sin_out),
        .busy      (busy)
    );

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int exp);
        logic ok;
        ok = ((obs - exp) <= TOL) && ((exp - obs) <= TOL);
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, TOL);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one angle, let the next edge accept it, then count edges until out_valid.
    task automatic run_op(input string tag, input int angle, output int lat, output logic got);
        in_valid = 1'b1;
        in_angle = angle[W-1:0];
        step();
        in_valid = 1'b0;
        chk_bit({tag, "_busy"}, busy, 1'b1);
        lat = 1;
        got = 1'b0;
        while (!got && lat < 100) begin
            if (out_valid) got = 1'b1;
            else begin
                step();
                lat++;
            end
        end
        // lat counts edges from the accept edge to the edge after which out_valid is high.
        lat = lat - 1;
        chk_bit({tag, "_out_valid_seen"}, got, 1'b1);
    endtask

    initial begin
        int   lat;
        logic got;
        logic seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_angle  = '0;
        out_ready = 1'b1;

        // ---- reset ----
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();
        chk_bit("rst_in_ready", in_ready, 1'b1);
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_int("rst_cos", int'(cos_out), 0);
        chk_int("rst_sin", int'(sin_out), 0);

        // ---- pi/6 ----
        run_op("pi6", ANG_PI6, lat, got);
        chk_int("pi6_latency", lat, 16);
        chk_tol("pi6_cos", int'(cos_out), COS_PI6);
        chk_tol("pi6_sin", int'(sin_out), SIN_PI6);
        step();
        chk_bit("pi6_valid_one_cycle", out_valid, 1'b0);
        chk_bit("pi6_in_ready_back", in_ready, 1'b1);

        // ---- angle 0 ----
        run_op("zero", 0, lat, got);
        chk_tol("zero_cos", int'(cos_out), ONE);
        chk_tol("zero_sin", int'(sin_out), 0);
        step();

        // ---- -pi/2 ----
        run_op("npi2", ANG_NPI2, lat, got);
        chk_tol("npi2_cos", int'(cos_out), 0);
        chk_tol("npi2_sin", int'(sin_out), -ONE);
        step();

        // ---- backpressure: result of angle 0 held for 10 cycles, new angle waiting ----
        out_ready = 1'b0;
        run_op("bp_first", 0, lat, got);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_angle = ANG_PI6[W-1:0];
            step();
            chk_bit("bp_hold_valid", out_valid, 1'b1);
            chk_bit("bp_hold_in_ready", in_ready, 1'b0);
            chk_tol("bp_hold_cos", int'(cos_out), ONE);
            chk_tol("bp_hold_sin", int'(sin_out), 0);
        end
        out_ready = 1'b1;
        step();
        chk_bit("bp_release_valid", out_valid, 1'b0);
        chk_bit("bp_release_in_ready", in_ready, 1'b1);
        chk_bit("bp_release_not_busy", busy, 1'b0);
        step();
        in_valid = 1'b0;
        chk_bit("bp_second_accepted", busy, 1'b1);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            step();
            lat++;
            if (out_valid) got = 1'b1;
        end
        chk_bit("bp_second_seen", got, 1'b1);
        chk_int("bp_second_latency", lat, 16);
        chk_tol("bp_second_cos", int'(cos_out), COS_PI6);
        chk_tol("bp_second_sin", int'(sin_out), SIN_PI6);
        step();

        // ---- reset in the middle of RUN ----
        in_valid = 1'b1;
        in_angle = ANG_PI6[W-1:0];
        step();
        in_valid = 1'b0;
        repeat (7) step();
        chk_bit("mid_busy_before_rst", busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_bit("mid_rst_busy", busy, 1'b0);
        chk_bit("mid_rst_out_valid", out_valid, 1'b0);
        chk_bit("mid_rst_in_ready", in_ready, 1'b1);
        chk_int("mid_rst_cos", int'(cos_out), 0);
        chk_int("mid_rst_sin", int'(sin_out), 0);
        seen = 1'b0;
        for (int k = 0; k < 24; k++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        chk_bit("mid_no_output", seen, 1'b0);
        run_op("mid_pi6", ANG_PI6, lat, got);
        chk_int("mid_pi6_latency", lat, 16);
        chk_tol("mid_pi6_cos", int'(cos_out), COS_PI6);
        chk_tol("mid_pi6_sin", int'(sin_out), SIN_PI6);
        step();

`ifdef CORDIC_SEQ_EARLY_EN
        // ---- early exit: angle equal to atan(1) entry ----
        run_op("early", 32'h000C90FD, lat, got);
        chk_int("early_z", int'(dut.z), 0);
        chk_int("early_latency", lat, 1);
        chk_int("early_cos", int'(cos_out), 32'h0009B74F);
        chk_int("early_sin", int'(sin_out), 32'h0009B74F);
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
